ifetch_unit: RTL

Instruction fetch stage for the single-cycle/pipelined MIPS core. Owns the program counter, drives the word address and read strobe of the instruction memory bank (64 × 32-bit, combinational read, 8-bit word address), and captures the returned word into the IF/ID pipeline register. Handles stall, branch/jump redirect with bubble insertion, and optional out-of-range fetch fault detection.

---
 rtl/ifetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage of the MIPS core. Owns the program counter, drives
// the word address and read strobe of a 64 x 32-bit combinational-read
// instruction memory, and captures the returned word into the IF/ID pipeline
// register. Handles hazard stalls and branch/jump redirects; each redirect
// inserts one bubble into IF/ID.
//
// Optional feature macro: IFETCH_FAULT_EN
//   defined   : any fetch with pc[31:2] >= IMEM_WORDS sets a sticky fault
//               that freezes the PC, feeds bubbles into IF/ID and gates the
//               read strobe until reset.
//   undefined : no range check; addresses alias through pc[9:2] and
//               fetch_fault is tied to 0.
//
// Parameters:
//   RESET_PC    byte address loaded into the PC on reset
//   IMEM_WORDS  instruction memory depth in words (fault range check)
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   stall            hazard-unit hold request (PC and IF/ID freeze)
//   branch_taken     EX-stage branch resolved taken
//   branch_target    branch byte address (low 2 bits ignored)
//   jump             ID-stage J/JAL decoded
//   jump_index       instruction[25:0] of the jump
//   imem_addr        word address to instruction memory (pc[9:2])
//   imem_read        read strobe to instruction memory
//   imem_data        instruction word returned by memory
//   if_id_instr      captured instruction (0 = NOP / bubble)
//   if_id_pc_plus4   PC+4 of the captured instruction
//   if_id_valid      IF/ID holds a real instruction
//   fetch_count      number of valid instructions loaded into IF/ID
//   fetch_fault      sticky out-of-range fetch flag
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [7:0]  imem_addr,
  output logic        imem_read,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

  localparam logic [29:0] IMEM_WORDS_W = 30'(IMEM_WORDS);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        run_q;
  logic        fault_q;
  logic        range_hit;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc[9:2];
  assign imem_read = run_q & ~stall & ~fault_q;

`ifdef IFETCH_FAULT_EN
  // A fetch beyond the memory is caught on the edge it would have been
  // captured, so the faulting word never reaches IF/ID.
  assign range_hit = run_q && (pc[31:2] >= IMEM_WORDS_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (range_hit) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign range_hit = 1'b0;
  assign fault_q   = 1'b0;
`endif

  assign fetch_fault = fault_q;

  // The branch target's low bits are forced to zero; the depth constant is
  // only consumed by the optional range check.
  logic unused_cfg;
  assign unused_cfg = ^{IMEM_WORDS_W, branch_target[1:0]};

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers (e.g. the jump uses the old
  // if_id_pc_plus4 while IF/ID is being overwritten in the same edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      run_q          <= 1'b0;
      if_id_instr    <= 32'h0000_0000;
      if_id_pc_plus4 <= 32'h0000_0000;
      if_id_valid    <= 1'b0;
      fetch_count    <= 32'h0000_0000;
    end else if (!run_q) begin
      // First edge after reset release only arms the fetch engine.
      run_q <= 1'b1;
    end else if (fault_q || range_hit) begin
      // Fault beats redirect: PC frozen, bubbles fed downstream.
      if_id_instr <= 32'h0000_0000;
      if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      pc          <= {branch_target[31:2], 2'b00};
      if_id_instr <= 32'h0000_0000;
      if_id_valid <= 1'b0;
    end else if (jump) begin
      pc          <= {if_id_pc_plus4[31:28], jump_index, 2'b00};
      if_id_instr <= 32'h0000_0000;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc             <= pc_plus4;
      if_id_instr    <= imem_data;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
      fetch_count    <= fetch_count + 32'd1;
    end
  end

endmodule
